// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int RADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per clock for WIDTH clocks after start.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH);

  // acc is the product high half / partial remainder; sh is the multiplier
  // being shifted out / dividend shifting into quotient.
  logic [WIDTH-1:0] acc, sh, op_b;
  logic [CW-1:0]    cnt;
  logic             run, div_q;

  logic [WIDTH:0] add_sum, sub_shift, sub_diff;

  assign add_sum   = {1'b0, acc} + (sh[0] ? {1'b0, op_b} : '0);
  assign sub_shift = {acc, sh[WIDTH-1]};
  assign sub_diff  = sub_shift - {1'b0, op_b};

  // Asserted during the final step so the FSM leaves CALC on that same edge.
  assign done    = run && (cnt == CW'(WIDTH-1));
  assign prod_hi = acc;
  assign prod_lo = sh;

  // Load operands on start, then run one iteration per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sh    <= '0;
      op_b  <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      div_q <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      sh    <= a;
      op_b  <= b;
      cnt   <= '0;
      run   <= 1'b1;
      div_q <= is_div;
    end else if (run) begin
      if (div_q) begin
        // Divide by zero naturally yields all-ones quotient, remainder = dividend.
        if (!sub_diff[WIDTH]) begin
          acc <= sub_diff[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b1};
        end else begin
          acc <= sub_shift[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= add_sum[WIDTH:1];
        sh  <= {add_sum[0], sh[WIDTH-1:1]};
      end
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: FSM, sign handling, HI/LO state and the
// registered MFHI/MFLO writeback port.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic [RADDR_W-1:0] dst,
  output logic               op_ready,
  output logic               busy,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_wn,
  output logic [WIDTH-1:0]   wb_wd,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e state;
  logic   neg_res_q, neg_rem_q, div_q, div0_q;

  logic             signed_op, rs_neg, rt_neg, start;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             core_done;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_ready = (state == ST_IDLE);
  assign busy     = !op_ready;

  assign signed_op = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign rs_neg    = signed_op && rs_val[WIDTH-1];
  assign rt_neg    = signed_op && rt_val[WIDTH-1];
  assign a_mag     = rs_neg ? -rs_val : rs_val;
  assign b_mag     = rt_neg ? -rt_val : rt_val;
  assign start     = op_valid && op_ready && !op[2];

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .is_div  (op[1]),
    .a       (a_mag),
    .b       (b_mag),
    .done    (core_done),
    .prod_hi (core_hi),
    .prod_lo (core_lo)
  );

  // Sign fix-up of the unsigned core result; div-by-zero forces LO to all ones
  // (the remainder already reconstructs rs_val once its sign is restored).
  assign prod     = {core_hi, core_lo};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = div0_q ? '1 : (neg_res_q ? -core_lo : core_lo);
  assign rem_fix  = neg_rem_q ? -core_hi : core_hi;

  // Control FSM plus HI/LO and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      wb_we     <= 1'b0;
      wb_wn     <= '0;
      wb_wd     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_e'(op))
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state     <= ST_CALC;
                neg_res_q <= rs_neg ^ rt_neg;
                neg_rem_q <= rs_neg;
                div_q     <= op[1];
                div0_q    <= op[1] && (rt_val == '0);
              end
              OP_MFHI: begin
                wb_we <= (dst != '0);
                wb_wn <= dst;
                wb_wd <= hi;
              end
              OP_MFLO: begin
                wb_we <= (dst != '0);
                wb_wn <= dst;
                wb_wd <= lo;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (core_done) state <= ST_FIX;
        end
        ST_FIX: begin
          if (div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with hand-computed expected values.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [4:0]  dst;
  logic        op_ready, busy, wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_wd, hi, lo;

  int tests = 0;
  int fails = 0;

  hilo_muldiv #(.WIDTH(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .dst(dst),
    .op_ready(op_ready), .busy(busy), .wb_we(wb_we), .wb_wn(wb_wn),
    .wb_wd(wb_wd), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b; dst = d;
    tick();
    op_valid = 1'b0;
  endtask

  // Issue a MUL/DIV, check 33 busy samples (edges 0..32) then HI/LO after edge 33.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lowcnt, wecnt;
    issue(o, a, b, 5'd0);
    lowcnt = op_ready ? 0 : 1;
    wecnt  = wb_we ? 1 : 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (!op_ready) lowcnt++;
      if (wb_we) wecnt++;
    end
    tick();
    chk({tag, "_busy_cycles"}, 32'(lowcnt), 32'd33);
    chk({tag, "_wb_we_quiet"}, 32'(wecnt), 32'd0);
    chk({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; dst = '0;
    #12;
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

    issue(3'd4, 32'd0, 32'd0, 5'd8);
    chk("mfhi8_we", {31'd0, wb_we}, 32'd1);
    chk("mfhi8_wn", {27'd0, wb_wn}, 32'd8);
    chk("mfhi8_wd", wb_wd, 32'h0000_0001);
    tick();
    chk("mfhi8_we_drop", {31'd0, wb_we}, 32'd0);

    run_md("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_z",   3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_md("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("div_z_neg", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MFLO held while a DIVU (100/7 -> q 14, r 2) is busy.
    issue(3'd3, 32'd100, 32'd7, 5'd0);
    op_valid = 1'b1; op = 3'd5; dst = 5'd3;
    cyc = 0;
    while (cyc < 40 && !wb_we) begin
      tick();
      cyc++;
    end
    op_valid = 1'b0;
    chk("mflo_held_cycle", 32'(cyc), 32'd34);
    chk("mflo_held_wd", wb_wd, 32'd14);
    chk("mflo_held_wn", {27'd0, wb_wn}, 32'd3);
    chk("divu_hi", hi, 32'd2);
    tick();
    chk("mflo_held_single", {31'd0, wb_we}, 32'd0);

    // MTHI then MFHI to r0 on the very next cycle.
    issue(3'd6, 32'hCAFE_F00D, 32'd0, 5'd0);
    op_valid = 1'b1; op = 3'd4; dst = 5'd0;
    tick();
    op_valid = 1'b0;
    chk("mthi_hi", hi, 32'hCAFE_F00D);
    chk("mfhi_r0_we", {31'd0, wb_we}, 32'd0);
    issue(3'd4, 32'd0, 32'd0, 5'd31);
    chk("mfhi31_we", {31'd0, wb_we}, 32'd1);
    chk("mfhi31_wn", {27'd0, wb_wn}, 32'd31);
    chk("mfhi31_wd", wb_wd, 32'hCAFE_F00D);

    // MTLO, then back-to-back MFLO/MFHI pulses.
    issue(3'd7, 32'h0000_0055, 32'd0, 5'd0);
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_no_we", {31'd0, wb_we}, 32'd0);
    op_valid = 1'b1; op = 3'd5; dst = 5'd5;
    tick();
    chk("b2b_1_we", {31'd0, wb_we}, 32'd1);
    chk("b2b_1_wd", wb_wd, 32'h0000_0055);
    op = 3'd4; dst = 5'd6;
    tick();
    op_valid = 1'b0;
    chk("b2b_2_we", {31'd0, wb_we}, 32'd1);
    chk("b2b_2_wn", {27'd0, wb_wn}, 32'd6);
    chk("b2b_2_wd", wb_wd, 32'hCAFE_F00D);

    // Async reset during CALC at count 10.
    issue(3'd1, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0);
    repeat (10) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, op_ready}, 32'd1);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_we", {31'd0, wb_we}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (40) tick();
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
